// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Round-robin increment that wraps explicitly at n-1, so it stays correct
  // for non-power-of-2 requester counts.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr == n - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module fifo_rr_picker #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                pick_valid,
  output logic [ID_WIDTH-1:0] pick_id
);

  localparam int unsigned W2 = 2 * NUM_REQ;

  logic [W2-1:0] dbl;
  logic [W2-1:0] mask;
  logic [W2-1:0] masked;

  // The upper copy is never masked, so the wrap-around search is a plain
  // lowest-set-bit scan over the doubled vector.
  assign dbl    = {req, req};
  assign mask   = {W2{1'b1}} << ptr;
  assign masked = dbl & mask;

  // Priority-encode the lowest surviving bit and fold it back into 0..NUM_REQ-1.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int unsigned i = 0; i < W2; i++) begin
      if (!pick_valid && masked[i]) begin
        pick_valid = 1'b1;
        pick_id    = (i >= NUM_REQ) ? ID_WIDTH'(i - NUM_REQ) : ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one synchronous FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ),
  parameter int unsigned CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id
);

  arb_state_e           state;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [CNT_WIDTH-1:0] burst_cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;

  logic                 pick_valid;
  logic [ID_WIDTH-1:0]  pick_id;
  logic                 own_valid;
  logic                 own_last;
  logic                 beat;
  logic                 release_grant;

  fifo_rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .pick_valid (pick_valid),
    .pick_id    (pick_id)
  );

  // Select the owner's handshake/data by the registered grant_id and drive its ready.
  always_comb begin
    own_valid    = 1'b0;
    own_last     = 1'b0;
    fifo_wr_data = '0;
    req_ready    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        own_valid    = req_valid[i];
        own_last     = req_last[i];
        fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = grant_valid & ~fifo_full;
      end
    end
  end

  assign beat       = grant_valid & own_valid & ~fifo_full;
  assign fifo_wr_en = beat;
  assign cnt_inc    = burst_cnt + 1'b1;

  // Abandon releases even while stalled; last/length release only on a real beat.
  assign release_grant = !own_valid ||
                         (beat && (own_last || (cnt_inc == CNT_WIDTH'(MAX_BURST))));

  // Arbitration FSM with registered grant, pointer and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_id    <= pick_id;
            grant_valid <= 1'b1;
            burst_cnt   <= '0;
            state       <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (release_grant) begin
            grant_valid <= 1'b0;
            rr_ptr      <= ID_WIDTH'(rr_next(32'(grant_id), NUM_REQ));
            burst_cnt   <= '0;
            state       <= ARB_IDLE;
          end else if (beat) begin
            burst_cnt <= cnt_inc;
          end
        end
        default: begin
          grant_valid <= 1'b0;
          state       <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
